// File: rtl/pc_sequencer_if.sv
// Next-PC control bundle between the PC sequencer and the PC register / hazard / branch logic.
// AlignFault exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_sequencer_if;
    logic [31:0] PCResult;
    logic        StallReq;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Address;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        Pending;
    logic [15:0] RedirectCount;
`ifdef PC_ALIGN_CHECK_EN
    logic        AlignFault;
`endif

    modport master (
        input  PCResult, StallReq, BranchTaken, BranchTarget, Jump, JumpTarget,
        output Address, PCWrite, IFIDWrite, IFIDFlush, Pending, RedirectCount
`ifdef PC_ALIGN_CHECK_EN
        , output AlignFault
`endif
    );

    modport slave (
        output PCResult, StallReq, BranchTaken, BranchTarget, Jump, JumpTarget,
        input  Address, PCWrite, IFIDWrite, IFIDFlush, Pending, RedirectCount
`ifdef PC_ALIGN_CHECK_EN
        , input AlignFault
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold, sequential fetch, jump/branch redirect, stall hold with one pending redirect.
// Optional PC_ALIGN_CHECK_EN: redirect targets are word-aligned and a sticky AlignFault flags misaligned ones.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 2,
    parameter int          STEP         = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

    state_t      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [15:0] redir_cnt_q, redir_cnt_d;

    logic [31:0] address;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;

    logic        redir_req;
    logic [31:0] redir_raw;
    logic [31:0] redir_tgt;

    // Jump has priority over a same-cycle taken branch.
    assign redir_req = bus.Jump | bus.BranchTaken;
    assign redir_raw = bus.Jump ? bus.JumpTarget : bus.BranchTarget;

`ifdef PC_ALIGN_CHECK_EN
    logic align_fault_q;
    logic redir_used;

    assign redir_tgt = {redir_raw[31:2], 2'b00};
    // A redirect is consumed in STALL (latched) or in RUN when nothing is already pending.
    assign redir_used = redir_req && ((state_q == STALL) || ((state_q == RUN) && !pend_q));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            align_fault_q <= 1'b0;
        end else if (redir_used && (redir_raw[1:0] != 2'b00)) begin
            align_fault_q <= 1'b1;
        end
    end

    assign bus.AlignFault = align_fault_q;
`else
    assign redir_tgt = redir_raw;
`endif

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        redir_cnt_d = redir_cnt_q;
        address     = RESET_VECTOR;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;

        case (state_q)
            BOOT: begin
                ifid_flush = 1'b1;
                if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end

            RUN: begin
                if (bus.StallReq) begin
                    address = bus.PCResult;
                    state_d = STALL;
                    if (redir_req && !pend_q) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_tgt;
                    end
                end else if (pend_q) begin
                    address     = pend_tgt_q;
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    pend_d      = 1'b0;
                    redir_cnt_d = redir_cnt_q + 16'd1;
                end else if (redir_req) begin
                    address     = redir_tgt;
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    redir_cnt_d = redir_cnt_q + 16'd1;
                end else begin
                    address    = bus.PCResult + 32'(STEP);
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end

            STALL: begin
                address = bus.PCResult;
                // Newest redirect seen during a stall replaces any older one.
                if (redir_req) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = redir_tgt;
                end
                if (!bus.StallReq) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= BOOT;
            boot_cnt_q  <= 4'd0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= 32'd0;
            redir_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.Address       = address;
    assign bus.PCWrite       = pc_write;
    assign bus.IFIDWrite     = ifid_write;
    assign bus.IFIDFlush     = ifid_flush;
    assign bus.Pending       = pend_q;
    assign bus.RedirectCount = redir_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised bench for pc_sequencer: a cycle-level behavioural model plus a PC register kept in the bench.
module tb_pc_sequencer;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          BOOTC = 2;
    localparam int          STEPB = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    pc_sequencer_if bus_if ();

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .BOOT_CYCLES  (BOOTC),
        .STEP         (STEPB)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if.master)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_boot;
    bit          m_stall;
    logic [31:0] m_pend[$];
    logic [15:0] m_cnt;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fix_tgt(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    task automatic drive_idle();
        bus_if.StallReq     = 1'b0;
        bus_if.BranchTaken  = 1'b0;
        bus_if.BranchTarget = 32'd0;
        bus_if.Jump         = 1'b0;
        bus_if.JumpTarget   = 32'd0;
    endtask

    // Asserts reset asynchronously, checks reset outputs, holds n cycles, releases just after an edge.
    task automatic do_reset(input int n);
        drive_idle();
        Reset = 1'b0;
        m_boot  = BOOTC;
        m_stall = 1'b0;
        m_pend.delete();
        m_cnt   = 16'd0;
        m_pc    = RV;
        bus_if.PCResult = m_pc;
        #1;
        check("rst_pending", {31'd0, bus_if.Pending}, 32'd0);
        check("rst_count", {16'd0, bus_if.RedirectCount}, 32'd0);
        repeat (n) @(posedge Clk);
        #1;
        check("rst_addr", bus_if.Address, RV);
        check("rst_pcwrite", {31'd0, bus_if.PCWrite}, 32'd0);
        check("rst_ifidwrite", {31'd0, bus_if.IFIDWrite}, 32'd0);
        check("rst_flush", {31'd0, bus_if.IFIDFlush}, 32'd1);
        Reset = 1'b1;
    endtask

    // One clock cycle: apply inputs, predict, compare at negedge, advance the PC register.
    task automatic step(input logic s, input logic bt, input logic [31:0] btg,
                        input logic j, input logic [31:0] jtg);
        logic [31:0] ea;
        logic        epw, eiw, efl, chk_addr, red, exp_pend;
        logic [31:0] tgt;
        logic [15:0] exp_cnt;
        bus_if.StallReq     = s;
        bus_if.BranchTaken  = bt;
        bus_if.BranchTarget = btg;
        bus_if.Jump         = j;
        bus_if.JumpTarget   = jtg;
        bus_if.PCResult     = m_pc;
        red      = j | bt;
        tgt      = fix_tgt(j ? jtg : btg);
        exp_pend = (m_pend.size() != 0);
        exp_cnt  = m_cnt;
        ea = m_pc; epw = 1'b0; eiw = 1'b0; efl = 1'b0; chk_addr = 1'b1;
        if (m_boot > 0) begin
            ea = RV; efl = 1'b1; m_boot--;
        end else if (m_stall) begin
            if (red) begin
                m_pend.delete();
                m_pend.push_back(tgt);
            end
            m_stall = s;
        end else if (s) begin
            chk_addr = 1'b0;
            if (red && m_pend.size() == 0) m_pend.push_back(tgt);
            m_stall = 1'b1;
        end else if (m_pend.size() != 0) begin
            ea = m_pend.pop_front(); epw = 1'b1; efl = 1'b1; m_cnt++;
        end else if (red) begin
            ea = tgt; epw = 1'b1; efl = 1'b1; m_cnt++;
        end else begin
            ea = m_pc + STEPB; epw = 1'b1; eiw = 1'b1;
        end
        @(negedge Clk);
        if (chk_addr) check("address", bus_if.Address, ea);
        check("pcwrite", {31'd0, bus_if.PCWrite}, {31'd0, epw});
        check("ifidwrite", {31'd0, bus_if.IFIDWrite}, {31'd0, eiw});
        check("ifidflush", {31'd0, bus_if.IFIDFlush}, {31'd0, efl});
        check("pending", {31'd0, bus_if.Pending}, {31'd0, exp_pend});
        check("redir_count", {16'd0, bus_if.RedirectCount}, {16'd0, exp_cnt});
        @(posedge Clk);
        #1;
        if (epw) m_pc = ea;
        bus_if.PCResult = m_pc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        drive_idle();
        bus_if.PCResult = RV;
        #2;
        do_reset(3);

        // Boot then sequential fetch up to 0x10, then a jump.
        idle(BOOTC + 4);
        check("pc_before_jump", m_pc, 32'h10);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
        check("jump_count", {16'd0, bus_if.RedirectCount}, 32'd1);
        idle(1);
        check("pc_after_jump", m_pc, 32'h104);

        // Two-cycle stall, then stall with a branch latched on its first cycle.
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(2);
        step(1'b1, 1'b1, 32'h40, 1'b0, 32'd0);
        check("pending_in_stall", {31'd0, bus_if.Pending}, 32'd1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        idle(2);
        check("pc_after_stall_branch", m_pc, 32'h44);

        // Jump beats a same-cycle branch.
        step(1'b0, 1'b1, 32'h300, 1'b1, 32'h200);
        idle(1);
        check("pc_after_jump_branch", m_pc, 32'h204);

        // Reset while a redirect is pending.
        step(1'b1, 1'b1, 32'h80, 1'b0, 32'd0);
        do_reset(2);
        idle(BOOTC + 1);
        check("pc_after_reboot", m_pc, RV + STEPB);

`ifdef PC_ALIGN_CHECK_EN
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h103);
        check("align_fault", {31'd0, bus_if.AlignFault}, 32'd1);
        check("aligned_pc", m_pc, 32'h100);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 6) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
